rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port of the RV32I core between NUM_REQ writeback sources (e.g. ALU, load unit, CSR unit).
- Arbitrates round-robin and registers the winner's destination, data and one-hot write-enable into one output stage.
- The one-hot enable is produced by instantiating decoder_5to32, so the register file needs no local address decode.

---
 rtl/rf_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// rf_wb_arbiter : round-robin arbiter for the shared register-file write port
// Revision      : 1.0
// ============================================================================

module decoder_5to32 (
   input  logic [4:0]  sel_i,
   input  logic        en_i,
   output logic [31:0] dec_o
);

   always_comb begin
      dec_o = '0;
      if (en_i) begin
         dec_o[sel_i] = 1'b1;
      end
   end

endmodule

module rf_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   input  logic [NUM_REQ*5-1:0]    req_rd_i,
   input  logic [NUM_REQ*XLEN-1:0] req_data_i,
   output logic [NUM_REQ-1:0]      req_ready_o,
   input  logic                    stall_i,
   output logic                    wr_valid_o,
   output logic [4:0]              wr_addr_o,
   output logic [XLEN-1:0]         wr_data_o,
   output logic [31:0]             wr_en_o,
   output logic [2:0]              grant_idx_o
);

   localparam int         MAX_REQ  = 8;
   localparam logic [3:0] NUM_REQ4 = 4'(NUM_REQ);
   localparam logic [2:0] LAST_REQ = 3'(NUM_REQ - 1);

   // Requester views padded to eight entries so a 3-bit index is always legal
   logic [MAX_REQ-1:0] valid_ext;
   logic [4:0]         rd_arr   [MAX_REQ];
   logic [XLEN-1:0]    data_arr [MAX_REQ];

   generate
      for (genvar k = 0; k < MAX_REQ; k++) begin : g_req
         if (k < NUM_REQ) begin : g_live
            assign valid_ext[k] = req_valid_i[k];
            assign rd_arr[k]    = req_rd_i[5*k +: 5];
            assign data_arr[k]  = req_data_i[XLEN*k +: XLEN];
         end else begin : g_pad
            assign valid_ext[k] = 1'b0;
            assign rd_arr[k]    = 5'd0;
            assign data_arr[k]  = '0;
         end
      end
   endgenerate

   logic [2:0]      ptr_q, ptr_d;
   logic            wr_valid_q, wr_valid_d;
   logic [4:0]      wr_addr_q, wr_addr_d;
   logic [XLEN-1:0] wr_data_q, wr_data_d;
   logic [31:0]     wr_en_q, wr_en_d;
   logic [2:0]      grant_idx_q, grant_idx_d;

   logic            gnt_any;
   logic [2:0]      gnt_idx;
   logic [3:0]      cand;
   logic [4:0]      win_rd;
   logic [XLEN-1:0] win_data;
   logic [31:0]     win_dec;

   // Search from the pointer upward, wrapping modulo NUM_REQ
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = 3'd0;
      cand    = 4'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr_q} + 4'(i);
         if (cand >= NUM_REQ4) begin
            cand = cand - NUM_REQ4;
         end
         if (!gnt_any && valid_ext[cand[2:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[2:0];
         end
      end
      if (stall_i || !rst_ni) begin
         gnt_any = 1'b0;
         gnt_idx = 3'd0;
      end
   end

   generate
      for (genvar k = 0; k < NUM_REQ; k++) begin : g_ready
         assign req_ready_o[k] = gnt_any && (gnt_idx == 3'(k));
      end
   endgenerate

   assign win_rd   = rd_arr[gnt_idx];
   assign win_data = data_arr[gnt_idx];

   decoder_5to32 u_dec (
      .sel_i (win_rd),
      .en_i  (1'b1),
      .dec_o (win_dec)
   );

   always_comb begin
      ptr_d       = ptr_q;
      wr_valid_d  = 1'b0;
      wr_en_d     = '0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      grant_idx_d = grant_idx_q;
      if (gnt_any) begin
         ptr_d       = (gnt_idx == LAST_REQ) ? 3'd0 : gnt_idx + 3'd1;
         // x0 grants are consumed but never reach the register file
         wr_valid_d  = (win_rd != 5'd0);
         wr_en_d     = win_dec & ~32'h1;
         wr_addr_d   = win_rd;
         wr_data_d   = win_data;
         grant_idx_d = gnt_idx;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr_q       <= 3'd0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= 5'd0;
         wr_data_q   <= '0;
         wr_en_q     <= '0;
         grant_idx_q <= 3'd0;
      end else begin
         ptr_q       <= ptr_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_en_q     <= wr_en_d;
         grant_idx_q <= grant_idx_d;
      end
   end

   assign wr_valid_o  = wr_valid_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;
   assign wr_en_o     = wr_en_q;
   assign grant_idx_o = grant_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_wb_arbiter : directed vectors with a queue-based write scoreboard
// Revision         : 1.0
// ============================================================================

module tb_rf_wb_arbiter;

   localparam int NUM_REQ = 3;
   localparam int XLEN    = 32;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    stall;
   logic [NUM_REQ-1:0]      valid;
   logic [NUM_REQ*5-1:0]    rd;
   logic [NUM_REQ*XLEN-1:0] data;
   logic [NUM_REQ-1:0]      req_ready_o;
   logic                    wr_valid_o;
   logic [4:0]              wr_addr_o;
   logic [XLEN-1:0]         wr_data_o;
   logic [31:0]             wr_en_o;
   logic [2:0]              grant_idx_o;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (valid),
      .req_rd_i    (rd),
      .req_data_i  (data),
      .req_ready_o (req_ready_o),
      .stall_i     (stall),
      .wr_valid_o  (wr_valid_o),
      .wr_addr_o   (wr_addr_o),
      .wr_data_o   (wr_data_o),
      .wr_en_o     (wr_en_o),
      .grant_idx_o (grant_idx_o)
   );

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] en;
      logic [2:0]  idx;
   } wr_t;

   wr_t  exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   vnum   = 0;
   logic mon_on = 1'b0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every committed write must match the oldest expected write
   always @(negedge clk) begin
      if (mon_on) begin
         if (wr_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_write: got addr %0d en %0h, expected no write",
                        wr_addr_o, wr_en_o);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("write", {wr_addr_o, wr_data_o, wr_en_o, grant_idx_o}, e);
            end
         end else begin
            check("idle_wr_en", wr_en_o, 80'd0);
         end
      end
   end

   // One cycle of stimulus; checks the combinational grant and books the write
   task automatic vec(input logic r, input logic s, input logic [2:0] v,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [2:0] exp_rdy);
      @(posedge clk);
      #1;
      vnum++;
      rst_n = r;
      stall = s;
      valid = v;
      rd    = {r2, r1, r0};
      data  = {4'hC, 20'(vnum), 3'd0, r2,
               4'hB, 20'(vnum), 3'd0, r1,
               4'hA, 20'(vnum), 3'd0, r0};
      #2;
      check("ready", req_ready_o, exp_rdy);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (exp_rdy[k] && rd[5*k +: 5] != 5'd0) begin
            wr_t e;
            e.addr = rd[5*k +: 5];
            e.data = data[32*k +: 32];
            e.en   = 32'h1 << rd[5*k +: 5];
            e.idx  = 3'(k);
            exp_q.push_back(e);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      valid = 3'b111;
      rd    = '0;
      data  = '0;

      // reset holds everything off even with all requesters valid
      vec(0, 0, 3'b111, 5, 6, 7, 3'b000);
      mon_on = 1'b1;
      vec(0, 0, 3'b111, 5, 6, 7, 3'b000);
      vec(0, 0, 3'b111, 5, 6, 7, 3'b000);
      check("reset_outs", {wr_valid_o, wr_addr_o, wr_data_o, grant_idx_o}, 80'd0);

      // round-robin with everyone requesting
      vec(1, 0, 3'b111, 5, 6, 7, 3'b001);
      vec(1, 0, 3'b111, 5, 6, 7, 3'b010);
      vec(1, 0, 3'b111, 5, 6, 7, 3'b100);
      vec(1, 0, 3'b111, 5, 6, 7, 3'b001);
      vec(1, 0, 3'b111, 5, 6, 7, 3'b010);
      vec(1, 0, 3'b111, 5, 6, 7, 3'b100);

      // sparse request wraps the pointer
      vec(1, 0, 3'b010, 5, 6, 7, 3'b010);
      vec(1, 0, 3'b001, 8, 0, 0, 3'b001);

      // x0 write on requester 1 is consumed but suppressed
      vec(1, 0, 3'b010, 0, 0, 0, 3'b010);
      vec(1, 0, 3'b000, 0, 0, 0, 3'b000);
      check("x0_grant_idx", grant_idx_o, 80'd1);
      check("x0_wr_valid", wr_valid_o, 80'd0);

      // write granted just before a stall still commits once
      vec(1, 0, 3'b100, 0, 0, 9, 3'b100);
      vec(1, 1, 3'b011, 10, 11, 0, 3'b000);
      vec(1, 1, 3'b011, 10, 11, 0, 3'b000);
      vec(1, 1, 3'b011, 10, 11, 0, 3'b000);
      vec(1, 0, 3'b011, 10, 11, 0, 3'b001);
      vec(1, 0, 3'b011, 10, 11, 0, 3'b010);

      // mid-operation reset clears outputs and the pointer
      vec(1, 0, 3'b101, 4, 0, 31, 3'b100);
      vec(1, 0, 3'b001, 4, 0, 31, 3'b001);
      vec(0, 0, 3'b111, 4, 0, 31, 3'b000);
      vec(1, 0, 3'b111, 12, 13, 14, 3'b001);
      check("rst_wr_en31", wr_en_o[31], 80'd0);
      check("rst_wr_valid", wr_valid_o, 80'd0);

      vec(1, 0, 3'b000, 0, 0, 0, 3'b000);
      vec(1, 0, 3'b000, 0, 0, 0, 3'b000);
      check("scoreboard_empty", 80'(exp_q.size()), 80'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
